// File: rtl/axi_lite_pkg.sv
// Shared response codes, FSM state types and register offsets for the AXI-Lite register slave.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    localparam logic [3:0] REG0_OFFSET = 4'h0;
    localparam logic [3:0] REG1_OFFSET = 4'h4;
    localparam logic [3:0] REG2_OFFSET = 4'h8;
    localparam logic [3:0] REG3_OFFSET = 4'hC;

    typedef enum logic [1:0] {
        W_IDLE,
        W_COMMIT,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/axi_lite_reg_decode.sv
// Combinational address decode: byte address -> register index, in-map flag, writable flag.
module axi_lite_reg_decode
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [1:0]            o_index,
    output logic                  o_valid,
    output logic                  o_writable
);

    logic [ADDR_WIDTH:0] w_offset;
    logic                w_in_range;
    logic                w_unused_lsb;

    // One extra bit so an address below BASE_ADDR can never alias into the map.
    assign w_offset   = {1'b0, i_addr} - (ADDR_WIDTH + 1)'(BASE_ADDR);
    assign w_in_range = ({1'b0, i_addr} >= (ADDR_WIDTH + 1)'(BASE_ADDR)) &&
                        (w_offset[ADDR_WIDTH:4] == '0);

    assign o_valid    = w_in_range && (i_addr[1:0] == 2'b00);
    assign o_index    = w_offset[3:2];
    assign o_writable = o_valid &&
                        ((w_offset[3:0] == REG0_OFFSET) || (w_offset[3:0] == REG1_OFFSET));

    assign w_unused_lsb = ^w_offset[1:0];

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave with two RW registers, a sum register and a write counter.
// Write and read channels are fully independent, one transaction outstanding on each.
module axi_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RESP_WIDTH = 3,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                    s_axi_aclk,
    input  logic                    s_axi_areset,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8:0]   s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [RESP_WIDTH-1:0]   s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [RESP_WIDTH-1:0]   s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [RESP_WIDTH-1:0] RESP_OK  = RESP_WIDTH'(RESP_OKAY);
    localparam logic [RESP_WIDTH-1:0] RESP_ERR = RESP_WIDTH'(RESP_SLVERR);

    wr_state_t r_wr_state, w_wr_state_next;
    rd_state_t r_rd_state, w_rd_state_next;

    logic                  r_aw_done, r_w_done;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [STRB_WIDTH-1:0] r_wstrb;
    logic [RESP_WIDTH-1:0] r_bresp;
    logic [DATA_WIDTH-1:0] r_reg0, r_reg1, r_wr_count;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [RESP_WIDTH-1:0] r_rresp;

    logic                  w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
    logic [1:0]            w_aw_idx, w_ar_idx;
    logic                  w_aw_valid, w_aw_writable, w_ar_valid, w_ar_writable;
    logic [DATA_WIDTH-1:0] w_wr_base, w_wr_merged, w_rd_value;
    logic                  w_unused_bits;

    assign s_axi_awready = (r_wr_state == W_IDLE) && !r_aw_done;
    assign s_axi_wready  = (r_wr_state == W_IDLE) && !r_w_done;
    assign s_axi_bvalid  = (r_wr_state == W_RESP);
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = (r_rd_state == R_IDLE);
    assign s_axi_rvalid  = (r_rd_state == R_DATA);
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;

    assign w_aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_w_hs  = s_axi_wvalid && s_axi_wready;
    assign w_b_hs  = s_axi_bvalid && s_axi_bready;
    assign w_ar_hs = s_axi_arvalid && s_axi_arready;
    assign w_r_hs  = s_axi_rvalid && s_axi_rready;

    axi_lite_reg_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR)
    ) u_aw_decode (
        .i_addr     (r_awaddr),
        .o_index    (w_aw_idx),
        .o_valid    (w_aw_valid),
        .o_writable (w_aw_writable)
    );

    axi_lite_reg_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .BASE_ADDR  (BASE_ADDR)
    ) u_ar_decode (
        .i_addr     (s_axi_araddr),
        .o_index    (w_ar_idx),
        .o_valid    (w_ar_valid),
        .o_writable (w_ar_writable)
    );

    // ---------------- write channel ----------------
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_wr_state <= W_IDLE;
        end else begin
            r_wr_state <= w_wr_state_next;
        end
    end

    always_comb begin
        w_wr_state_next = r_wr_state;
        unique case (r_wr_state)
            W_IDLE: begin
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                    w_wr_state_next = W_COMMIT;
                end
            end
            W_COMMIT: w_wr_state_next = W_RESP;
            W_RESP: begin
                if (w_b_hs) begin
                    w_wr_state_next = W_IDLE;
                end
            end
            default: w_wr_state_next = W_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            if (w_aw_hs) begin
                r_awaddr  <= s_axi_awaddr;
                r_aw_done <= 1'b1;
            end
            if (w_w_hs) begin
                r_wdata  <= s_axi_wdata;
                r_wstrb  <= s_axi_wstrb[STRB_WIDTH-1:0];
                r_w_done <= 1'b1;
            end
            if (w_b_hs) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end
        end
    end

    always_comb begin
        w_wr_base   = (w_aw_idx == REG1_OFFSET[3:2]) ? r_reg1 : r_reg0;
        w_wr_merged = w_wr_base;
        for (int i = 0; i < STRB_WIDTH; i++) begin
            if (r_wstrb[i]) begin
                w_wr_merged[8*i +: 8] = r_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_reg0     <= '0;
            r_reg1     <= '0;
            r_wr_count <= '0;
            r_bresp    <= '0;
        end else if (r_wr_state == W_COMMIT) begin
            if (w_aw_writable) begin
                if (w_aw_idx == REG0_OFFSET[3:2]) begin
                    r_reg0 <= w_wr_merged;
                end else begin
                    r_reg1 <= w_wr_merged;
                end
                r_wr_count <= r_wr_count + 1'b1;
                r_bresp    <= RESP_OK;
            end else begin
                r_bresp <= RESP_ERR;
            end
        end
    end

    // ---------------- read channel ----------------
    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_rd_state <= R_IDLE;
        end else begin
            r_rd_state <= w_rd_state_next;
        end
    end

    always_comb begin
        w_rd_state_next = r_rd_state;
        unique case (r_rd_state)
            R_IDLE: begin
                if (w_ar_hs) begin
                    w_rd_state_next = R_DATA;
                end
            end
            R_DATA: begin
                if (w_r_hs) begin
                    w_rd_state_next = R_IDLE;
                end
            end
            default: w_rd_state_next = R_IDLE;
        endcase
    end

    // Samples registered state, so a read landing on the commit edge sees the pre-write value.
    always_comb begin
        w_rd_value = '0;
        case ({w_ar_idx, 2'b00})
            REG0_OFFSET: w_rd_value = r_reg0;
            REG1_OFFSET: w_rd_value = r_reg1;
            REG2_OFFSET: w_rd_value = r_reg0 + r_reg1;
            REG3_OFFSET: w_rd_value = r_wr_count;
            default:     w_rd_value = '0;
        endcase
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_rdata <= '0;
            r_rresp <= '0;
        end else if (w_ar_hs) begin
            if (w_ar_valid) begin
                r_rdata <= w_rd_value;
                r_rresp <= RESP_OK;
            end else begin
                r_rdata <= '0;
                r_rresp <= RESP_ERR;
            end
        end
    end

    assign w_unused_bits = ^{s_axi_wstrb[STRB_WIDTH], w_aw_valid, w_ar_writable};

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Randomized bench for axi_lite_reg_slave: transaction-level register model, per-cycle response
// checks against expected-response queues, plus literal expectations for the key scenarios.
module tb_axi_lite_reg_slave;

    localparam int BASE = 0;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic [7:0]  awaddr = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [4:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [2:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [7:0]  araddr = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [2:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;

    always #5 clk = ~clk;

    axi_lite_reg_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8),
        .RESP_WIDTH (3),
        .BASE_ADDR  (BASE)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_areset  (areset),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready)
    );

    int checks = 0;
    int errors = 0;

    // Register model and queues of responses the DUT still owes.
    logic [31:0] m_reg0 = '0, m_reg1 = '0, m_cnt = '0;
    logic [2:0]  exp_b[$];
    logic [34:0] exp_r[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic m_addr_ok(input logic [7:0] a);
        int off;
        off = int'(a) - BASE;
        return (off >= 0) && (off < 16) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [2:0] m_write(input logic [7:0] a, input logic [31:0] d,
                                           input logic [4:0] s);
        int          off;
        logic [31:0] cur;
        off = int'(a) - BASE;
        if (!m_addr_ok(a) || off >= 8) return 3'd2;
        cur = (off == 0) ? m_reg0 : m_reg1;
        for (int i = 0; i < 4; i++) if (s[i]) cur[8*i +: 8] = d[8*i +: 8];
        if (off == 0) m_reg0 = cur;
        else m_reg1 = cur;
        m_cnt = m_cnt + 1;
        return 3'd0;
    endfunction

    task automatic m_read(input logic [7:0] a, output logic [31:0] d, output logic [2:0] r);
        int off;
        off = int'(a) - BASE;
        if (!m_addr_ok(a)) begin
            d = '0;
            r = 3'd2;
        end else begin
            case (off / 4)
                0: d = m_reg0;
                1: d = m_reg1;
                2: d = m_reg0 + m_reg1;
                default: d = m_cnt;
            endcase
            r = 3'd0;
        end
    endtask

    // Every cycle a response is presented it must match the oldest owed response.
    always @(negedge clk) begin
        if (!areset) begin
            if (bvalid) begin
                if (exp_b.size() == 0) chk("b_unexpected", bvalid, 1'b0);
                else begin
                    chk("bresp_model", bresp, exp_b[0]);
                    if (bready) void'(exp_b.pop_front());
                end
            end
            if (rvalid) begin
                if (exp_r.size() == 0) chk("r_unexpected", rvalid, 1'b0);
                else begin
                    chk("r_model", {rresp, rdata}, exp_r[0]);
                    if (rready) void'(exp_r.pop_front());
                end
            end
        end
    end

    // All driver tasks start and end at posedge + 1.
    task automatic send_aw(input logic [7:0] a, input int dly);
        bit ok = 0;
        repeat (dly) begin @(posedge clk); #1; end
        awaddr = a; awvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); if (awready) ok = 1; end
        @(posedge clk); #1; awvalid = 1'b0;
        chk("aw_accept", ok, 1);
    endtask

    task automatic send_w(input logic [31:0] d, input logic [4:0] s, input int dly);
        bit ok = 0;
        repeat (dly) begin @(posedge clk); #1; end
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); if (wready) ok = 1; end
        @(posedge clk); #1; wvalid = 1'b0;
        chk("w_accept", ok, 1);
    endtask

    task automatic send_ar(input logic [7:0] a, input int dly);
        bit ok = 0;
        repeat (dly) begin @(posedge clk); #1; end
        araddr = a; arvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); if (arready) ok = 1; end
        @(posedge clk); #1; arvalid = 1'b0;
        chk("ar_accept", ok, 1);
    endtask

    task automatic recv_b(input int hold, output logic [2:0] resp, output int lat);
        bit seen = 0;
        lat = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk); lat++;
            if (bvalid) seen = 1;
        end
        chk("b_arrive", seen, 1);
        resp = bresp;
        repeat (hold) begin
            @(negedge clk);
            chk("b_held", {bvalid, awready, wready}, 3'b100);
        end
        @(posedge clk); #1; bready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1; bready = 1'b0;
        @(negedge clk);
        chk("b_done", {bvalid, awready, wready}, 3'b011);
        @(posedge clk); #1;
    endtask

    task automatic recv_r(input int hold, output logic [31:0] d, output logic [2:0] r);
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); if (rvalid) seen = 1; end
        chk("r_arrive", seen, 1);
        d = rdata; r = rresp;
        repeat (hold) begin
            @(negedge clk);
            chk("r_held", {rvalid, arready, rdata}, {2'b10, d});
        end
        @(posedge clk); #1; rready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1; rready = 1'b0;
        @(negedge clk);
        chk("r_done", {rvalid, arready}, 2'b01);
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [4:0] s,
                            input int ad, input int wd, input int hold,
                            output logic [2:0] resp, output int lat);
        exp_b.push_back(m_write(a, d, s));
        fork
            send_aw(a, ad);
            send_w(d, s, wd);
        join
        recv_b(hold, resp, lat);
    endtask

    task automatic do_read(input logic [7:0] a, input int ad, input int hold,
                           output logic [31:0] d, output logic [2:0] r);
        logic [31:0] ed;
        logic [2:0]  er;
        m_read(a, ed, er);
        exp_r.push_back({er, ed});
        send_ar(a, ad);
        recv_r(hold, d, r);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1; areset = 1'b1;
        @(posedge clk); #1; areset = 1'b0;
        exp_b.delete(); exp_r.delete();
        m_reg0 = '0; m_reg1 = '0; m_cnt = '0;
        @(negedge clk);
        chk("reset_ctrl", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
        chk("reset_data", {bresp, rresp, rdata}, '0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] d;
        logic [2:0]  r;
        int          lat;
        bit          seen;
        logic [7:0]  bad [4] = '{8'h08, 8'h0C, 8'h20, 8'h02};
        logic [7:0]  a;

        repeat (3) @(posedge clk);
        #1; areset = 1'b0;
        @(negedge clk);
        chk("init_ctrl", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
        chk("init_data", {bresp, rresp, rdata}, '0);
        @(posedge clk); #1;

        // Sum register wraps; counter counts successful writes.
        do_write(8'h00, 32'hFFFF_FFFF, 5'h0F, 0, 0, 0, r, lat);
        do_write(8'h04, 32'h0000_0002, 5'h0F, 1, 0, 0, r, lat);
        do_read(8'h08, 0, 0, d, r);
        chk("reg2_wrap", d, 32'h0000_0001);
        do_read(8'h0C, 0, 0, d, r);
        chk("reg3_count2", d, 32'd2);

        // Same-cycle AW+W: response two cycles after the handshake.
        do_write(8'h00, 32'h1234_5678, 5'h0F, 0, 0, 0, r, lat);
        chk("b_latency", lat, 2);
        chk("bresp_okay", r, 3'd0);
        do_read(8'h00, 0, 0, d, r);
        chk("reg0_read", {r, d}, {3'd0, 32'h1234_5678});

        // W two cycles ahead of AW, partial strobes.
        do_write(8'h04, 32'h0, 5'h0F, 0, 0, 0, r, lat);
        do_write(8'h04, 32'hAABB_CCDD, 5'h05, 2, 0, 0, r, lat);
        do_read(8'h04, 0, 0, d, r);
        chk("reg1_strobe", d, 32'h00BB_00DD);

        // Illegal writes leave all state alone.
        for (int i = 0; i < 4; i++) begin
            do_write(bad[i], $urandom, 5'h0F, 0, 0, 0, r, lat);
            chk("bad_write_slverr", r, 3'd2);
        end
        do_read(8'h20, 0, 0, d, r);
        chk("bad_read", {r, d}, {3'd2, 32'h0});
        do_read(8'h00, 0, 0, d, r);
        chk("reg0_kept", d, 32'h1234_5678);
        do_read(8'h08, 0, 0, d, r);
        chk("reg2_sum", d, 32'h12EF_5755);
        do_read(8'h0C, 0, 0, d, r);
        chk("reg3_count5", d, 32'd5);

        // Back-pressure on both response channels.
        do_write(8'h00, 32'h0BAD_F00D, 5'h0F, 0, 0, 10, r, lat);
        do_read(8'h00, 0, 10, d, r);
        chk("reg0_held_read", d, 32'h0BAD_F00D);

        // Read accepted on the commit edge sees the old value.
        m_read(8'h00, d, r);
        exp_r.push_back({r, d});
        exp_b.push_back(m_write(8'h00, 32'h5555_AAAA, 5'h0F));
        fork
            send_aw(8'h00, 0);
            send_w(32'h5555_AAAA, 5'h0F, 0);
            send_ar(8'h00, 1);
        join
        recv_b(0, r, lat);
        recv_r(0, d, r);
        chk("collision_old", d, 32'h0BAD_F00D);
        do_read(8'h00, 0, 0, d, r);
        chk("collision_new", d, 32'h5555_AAAA);

        // All-zero strobes (only the ignored top bit set): OKAY, counted, data untouched.
        do_write(8'h04, 32'hFFFF_FFFF, 5'h10, 0, 1, 0, r, lat);
        chk("zero_strb_okay", r, 3'd0);
        do_read(8'h04, 0, 0, d, r);
        chk("zero_strb_data", d, 32'h00BB_00DD);
        do_read(8'h0C, 0, 0, d, r);
        chk("reg3_count8", d, 32'd8);

        // Reset while both responses are pending.
        exp_b.push_back(m_write(8'h00, 32'hCAFE_F00D, 5'h0F));
        fork
            send_aw(8'h00, 0);
            send_w(32'hCAFE_F00D, 5'h0F, 0);
        join
        m_read(8'h04, d, r);
        exp_r.push_back({r, d});
        send_ar(8'h04, 0);
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (bvalid && rvalid) seen = 1;
        end
        chk("pending_both", seen, 1);
        apply_reset();
        do_read(8'h00, 0, 0, d, r);
        chk("reset_reg0", d, 32'h0);
        do_read(8'h0C, 0, 0, d, r);
        chk("reset_reg3", d, 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 5))
                0: a = 8'h00;
                1: a = 8'h04;
                2: a = 8'h08;
                3: a = 8'h0C;
                4: a = 8'($urandom_range(0, 255));
                default: a = 8'($urandom_range(0, 19));
            endcase
            if ($urandom_range(0, 1) == 0) begin
                do_write(a, $urandom, 5'($urandom_range(0, 31)), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3), r, lat);
            end else begin
                do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), d, r);
            end
        end

        repeat (2) @(posedge clk);
        chk("b_queue_drained", exp_b.size(), 0);
        chk("r_queue_drained", exp_r.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
